// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - multi-channel fractional clock-enable generator with PLL-lock sequencing
module clk_enable_gen #(
   parameter int CHANNELS    = 4,
   parameter int ACC_W       = 16,
   parameter int LOCK_CYCLES = 1024,
   parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pll_lock,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic                cfg_sel,
   input  logic [ACC_W-1:0]    cfg_data,
   output logic                locked,
   output logic                rst_out,
   output logic [CHANNELS-1:0] ce
);

   localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

   typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, lk_q;
   logic             run;
   logic             cfg_hit;

   assign run     = (state_q == RUN);
   assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         lk_q    <= 1'b0;
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         locked  <= 1'b0;
         rst_out <= 1'b1;
      end else begin
         sync1_q <= pll_lock;
         lk_q    <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         locked  <= run;
         rst_out <= !run;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            cnt_d = '0;
            if (lk_q) state_d = SETTLE;
         end
         SETTLE: begin
            if (!lk_q) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            cnt_d = '0;
            if (!lk_q) state_d = WAIT_LOCK;
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [ACC_W-1:0] inc_q, mod_q, acc_q;
      logic             ce_q;
      logic [ACC_W:0]   sum;
      logic             wr_hit;

      assign sum    = {1'b0, acc_q} + {1'b0, inc_q};
      assign wr_hit = cfg_hit && (cfg_ch == CH_W'(g));
      assign ce[g]  = ce_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            inc_q <= '0;
            mod_q <= '0;
            acc_q <= '0;
            ce_q  <= 1'b0;
         end else begin
            if (wr_hit && !cfg_sel) inc_q <= cfg_data;
            if (wr_hit && cfg_sel)  mod_q <= cfg_data;
            // a write restarts the channel's phase, overriding any overflow this cycle
            if (wr_hit || !run || (mod_q == '0)) begin
               acc_q <= '0;
               ce_q  <= 1'b0;
            end else if (inc_q >= mod_q) begin
               acc_q <= '0;
               ce_q  <= 1'b1;
            end else if (sum >= {1'b0, mod_q}) begin
               acc_q <= sum[ACC_W-1:0] - mod_q;
               ce_q  <= 1'b1;
            end else begin
               acc_q <= sum[ACC_W-1:0];
               ce_q  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb/tb_clk_enable_gen.sv - directed self-checking bench for clk_enable_gen
module tb_clk_enable_gen;

   logic        clk;
   logic        reset;
   logic        pll_lock;
   logic        cfg_we;
   logic [2:0]  cfg_ch;
   logic        cfg_sel;
   logic [15:0] cfg_data;
   logic        locked;
   logic        rst_out;
   logic [4:0]  ce;

   int total = 0;
   int bad   = 0;
   int ones;
   logic [4:0] e;

   clk_enable_gen #(
      .CHANNELS(5),
      .ACC_W(16),
      .LOCK_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pll_lock(pll_lock),
      .cfg_we(cfg_we),
      .cfg_ch(cfg_ch),
      .cfg_sel(cfg_sel),
      .cfg_data(cfg_data),
      .locked(locked),
      .rst_out(rst_out),
      .ce(ce)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] ch, input logic sel, input logic [15:0] data);
      cfg_we   = 1'b1;
      cfg_ch   = ch;
      cfg_sel  = sel;
      cfg_data = data;
      tick();
      cfg_we   = 1'b0;
   endtask

   // inc=3/mod=8 from acc=0, sample 0 being the locked-rise cycle
   function automatic logic base_ce0(input int i);
      int m;
      m = i % 8;
      return (m == 2) || (m == 5) || (m == 7);
   endfunction

   // inc=3/mod=8 after a write cleared acc at r=0
   function automatic logic post_ce0(input int r);
      int m;
      m = r % 8;
      return (r >= 1) && ((m == 3) || (m == 6) || (m == 0));
   endfunction

   initial begin
      reset = 1'b1; pll_lock = 1'b0; cfg_we = 1'b0;
      cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
      tick(); tick();
      chk("reset_locked", locked, 0);
      chk("reset_rst_out", rst_out, 1);
      chk("reset_ce", ce, 0);
      reset = 1'b0;

      wr(0, 0, 3); wr(0, 1, 8); wr(1, 0, 5); wr(2, 0, 1); wr(2, 1, 2);
      chk("cfg_outside_run_ce", ce, 0);

      // lock glitch: drop after counter reaches 8 in SETTLE
      pll_lock = 1'b1;
      repeat (11) tick();
      pll_lock = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("glitch_rst_out", rst_out, 1);
         chk("glitch_locked", locked, 0);
      end

      // full lock sequence: present at edge 1, release after edge 20
      pll_lock = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         tick();
         chk("seq_rst_out_high", rst_out, 1);
         chk("seq_locked_low", locked, 0);
      end
      tick();
      chk("seq_locked_rise", locked, 1);
      chk("seq_rst_out_fall", rst_out, 0);

      ones = 0;
      for (int idx = 0; idx < 80; idx++) begin
         if (idx > 0) tick();
         e = {2'b00, logic'(idx[0]), 1'b0, base_ce0(idx)};
         chk("ratio_ce", ce, e);
         ones += int'(ce[0]);
      end
      chk("ratio_pulse_count", ones, 30);

      // write/overflow collision at idx 82, out-of-range writes at idx 90/91
      for (int idx = 80; idx < 104; idx++) begin
         cfg_we   = (idx == 82) || (idx == 90) || (idx == 91);
         cfg_ch   = (idx == 82) ? 3'd0 : ((idx == 90) ? 3'd5 : 3'd7);
         cfg_sel  = (idx == 90);
         cfg_data = (idx == 82) ? 16'd3 : ((idx == 90) ? 16'd1 : 16'd0);
         tick();
         cfg_we = 1'b0;
         e = {2'b00, logic'(idx[0]), 1'b0, (idx < 82) ? base_ce0(idx) : post_ce0(idx - 82)};
         chk("collision_ce", ce, e);
      end

      // degenerate ratios
      wr(3, 0, 8); wr(3, 1, 8); wr(4, 0, 9); wr(4, 1, 8);
      chk("degen_after_write", ce[4:3], 2'b01);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("degen_const", ce[4:3], 2'b11);
      end
      wr(3, 1, 0);
      chk("degen_mod0_write", ce[4:3], 2'b10);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("degen_mod0_hold", ce[4:3], 2'b10);
      end

      // lock loss in RUN
      pll_lock = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("loss_locked_hold", locked, 1);
         chk("loss_ce4_hold", ce[4], 1);
      end
      tick();
      chk("loss_locked", locked, 0);
      chk("loss_rst_out", rst_out, 1);
      chk("loss_ce", ce, 0);
      repeat (5) tick();
      chk("loss_ce_idle", ce, 0);

      pll_lock = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         tick();
         chk("relock_rst_out_high", rst_out, 1);
      end
      tick();
      chk("relock_locked", locked, 1);
      for (int idx = 0; idx < 16; idx++) begin
         if (idx > 0) tick();
         e = {1'b1, 1'b0, logic'(idx[0]), 1'b0, base_ce0(idx)};
         chk("relock_ce", ce, e);
      end

      // reset mid-run clears config and restarts sequencing
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset_locked", locked, 0);
      chk("midreset_rst_out", rst_out, 1);
      chk("midreset_ce", ce, 0);
      for (int k = 1; k <= 19; k++) begin
         tick();
         chk("midreset_seq_rst_out", rst_out, 1);
      end
      tick();
      chk("midreset_relocked", locked, 1);
      for (int k = 0; k < 16; k++) begin
         chk("midreset_cfg_cleared_ce", ce, 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
